vip_pixel_core: RTL and testbench

- Parametrised successor to the single-pixel FIFO-to-FIFO core in the video pipeline.
- Pops pixels from an upstream standard-mode FIFO, applies a per-channel operation selected at run time, and pushes results into a downstream FIFO.
- Tolerates downstream back-pressure without loss: an internal output buffer plus a credit check on read issue.
- Sits between the capture/line FIFOs and the display/next-stage FIFOs.

---
 rtl/vip_pixel_core.sv | 128 ++++++++++++
 tb/tb_vip_pixel_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vip_pixel_core.sv
// rtl/vip_pixel_core.sv - FIFO-to-FIFO per-channel pixel operator with credit-checked output buffer
// Optional pixel counter enabled by defining VIP_PIXEL_CORE_PIXCNT_EN.
`timescale 1ns/1ps
module vip_pixel_core #(
    parameter int  CH_WIDTH   = 8,
    parameter int  NUM_CH     = 3,
    parameter int  OBUF_DEPTH = 4,
    localparam int DWIDTH     = CH_WIDTH * NUM_CH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CH_WIDTH-1:0] thresh,
    input  logic [DWIDTH-1:0] ff_rdata,
    output logic              ff_rdreq,
    input  logic              ff_empty,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq,
    input  logic              ff_full,
    output logic              busy,
    output logic [31:0]       pix_count
);

    localparam int AW = $clog2(OBUF_DEPTH);
    localparam int CW = AW + 2;

    logic                r_s1_valid;
    logic [1:0]          r_s1_mode;
    logic [CH_WIDTH-1:0] r_s1_thresh;
    logic [1:0]          r_in_flight;
    logic [DWIDTH-1:0]   r_mem [OBUF_DEPTH];
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [AW:0]         r_count;

    logic [CW-1:0]       w_used;
    logic                w_rd;
    logic                w_wr;
    logic                w_s2_wr;
    logic [DWIDTH-1:0]   w_grey;
    logic [DWIDTH-1:0]   w_result;

    // Credit covers both buffered entries and reads whose data has not landed yet.
    assign w_used  = CW'(r_count) + CW'(r_in_flight);
    assign w_rd    = enable & ~ff_empty & (w_used < CW'(OBUF_DEPTH)) & ~reset;
    assign w_wr    = (r_count != '0) & ~ff_full & ~reset;
    assign w_s2_wr = r_s1_valid & ~reset;

    generate
        if (NUM_CH == 3) begin : g_grey
            logic [CH_WIDTH+1:0] w_sum;
            assign w_sum  = {2'b00, ff_rdata[CH_WIDTH-1:0]}
                          + {1'b0, ff_rdata[2*CH_WIDTH-1:CH_WIDTH], 1'b0}
                          + {2'b00, ff_rdata[3*CH_WIDTH-1:2*CH_WIDTH]};
            assign w_grey = {NUM_CH{w_sum[CH_WIDTH+1:2]}};
        end else begin : g_no_grey
            assign w_grey = ff_rdata;
        end
    endgenerate

    always_comb begin
        w_result = ff_rdata;
        case (r_s1_mode)
            2'd1: w_result = ~ff_rdata;
            2'd2: w_result = w_grey;
            2'd3: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    w_result[c*CH_WIDTH +: CH_WIDTH] =
                        (ff_rdata[c*CH_WIDTH +: CH_WIDTH] >= r_s1_thresh) ? {CH_WIDTH{1'b1}} : {CH_WIDTH{1'b0}};
                end
            end
            default: w_result = ff_rdata;
        endcase
    end

    // Mode and threshold are latched at read issue so in-flight pixels keep their operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 2'd0;
            r_s1_thresh <= '0;
            r_in_flight <= 2'd0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_s1_valid  <= w_rd;
            if (w_rd) begin
                r_s1_mode   <= mode;
                r_s1_thresh <= thresh;
            end
            r_in_flight <= r_in_flight + {1'b0, w_rd} - {1'b0, w_s2_wr};
            if (w_s2_wr) r_tail <= r_tail + 1'b1;
            if (w_wr)    r_head <= r_head + 1'b1;
            case ({w_s2_wr, w_wr})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_s2_wr) r_mem[r_tail] <= w_result;
    end

    always_ff @(posedge clock) begin
        if (!reset) assert (!(w_s2_wr && r_count == (AW+1)'(OBUF_DEPTH)));
    end

    assign ff_rdreq = w_rd;
    assign ff_wrreq = w_wr;
    assign ff_wdata = (w_wr || (r_count != '0 && !reset)) ? r_mem[r_head] : '0;
    assign busy     = ~reset & ((r_in_flight != 2'd0) | (r_count != '0) | r_s1_valid);

`ifdef VIP_PIXEL_CORE_PIXCNT_EN
    logic [31:0] r_pix_count;
    always_ff @(posedge clock) begin
        if (reset)     r_pix_count <= 32'd0;
        else if (w_wr) r_pix_count <= r_pix_count + 32'd1;
    end
    assign pix_count = reset ? 32'd0 : r_pix_count;
`else
    assign pix_count = 32'd0;
`endif

endmodule

// File: tb/tb_vip_pixel_core.sv
// tb/tb_vip_pixel_core.sv - scoreboard bench for vip_pixel_core with a modelled upstream FIFO
`timescale 1ns/1ps
module tb_vip_pixel_core;

    localparam int OBUF_DEPTH = 4;

    typedef struct {
        logic [23:0] data;
        logic [1:0]  mode;
        logic [7:0]  thresh;
        logic [23:0] exp;
    } pix_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thresh = 8'd0;
    logic [23:0] ff_rdata = 24'd0;
    logic        ff_rdreq;
    logic        ff_empty = 1'b1;
    logic [23:0] ff_wdata;
    logic        ff_wrreq;
    logic        ff_full = 1'b0;
    logic        busy;
    logic [31:0] pix_count;

    pix_t        up_q[$];
    logic [23:0] sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          rd_cyc = -1;
    int          wr_cyc = -1;
    bit          lat_arm = 1'b0;

    vip_pixel_core #(.CH_WIDTH(8), .NUM_CH(3), .OBUF_DEPTH(OBUF_DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .thresh    (thresh),
        .ff_rdata  (ff_rdata),
        .ff_rdreq  (ff_rdreq),
        .ff_empty  (ff_empty),
        .ff_wdata  (ff_wdata),
        .ff_wrreq  (ff_wrreq),
        .ff_full   (ff_full),
        .busy      (busy),
        .pix_count (pix_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic [1:0] m, input logic [7:0] t, input logic [23:0] e);
        pix_t p;
        p.data = d; p.mode = m; p.thresh = t; p.exp = e;
        up_q.push_back(p);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clock);
            if (up_q.size() == 0 && sb.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size() + up_q.size());
        end
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Upstream FIFO model: data returns one cycle after a pop; mode/thresh follow the head entry.
    initial begin : upstream
        bit   rd;
        pix_t p;
        forever begin
            @(negedge clock);
            rd = ff_rdreq;
            @(posedge clock);
            #1;
            if (rd && up_q.size() != 0) begin
                p = up_q.pop_front();
                ff_rdata = p.data;
                sb.push_back(p.exp);
            end else begin
                ff_rdata = 24'($urandom);
            end
            ff_empty = (up_q.size() == 0);
            if (up_q.size() != 0) begin
                mode   = up_q[0].mode;
                thresh = up_q[0].thresh;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                n_rd = 0;
                n_wr = 0;
            end else begin
                if (ff_rdreq) begin
                    n_rd++;
                    if (lat_arm && rd_cyc < 0) rd_cyc = cyc;
                end
                if (ff_wrreq) begin
                    n_wr++;
                    if (lat_arm && wr_cyc < 0) wr_cyc = cyc;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: got 0x%06h expected no write", ff_wdata);
                    end else begin
                        check("wdata", {8'd0, ff_wdata}, {8'd0, sb.pop_front()});
                    end
                end
                if (n_rd - n_wr > OBUF_DEPTH) check("credit", 32'(n_rd - n_wr), OBUF_DEPTH);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        bit found;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rdreq", {31'd0, ff_rdreq}, 32'd0);
        check("rst_wrreq", {31'd0, ff_wrreq}, 32'd0);
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_wdata", {8'd0, ff_wdata}, 32'd0);
        check("init_pix_count", pix_count, 32'd0);

        // Mode 0 stream and latency
        enable = 1'b1;
        rd_cyc = -1; wr_cyc = -1; lat_arm = 1'b1;
        @(posedge clock); #2;
        push(24'h010203, 2'd0, 8'h00, 24'h010203);
        push(24'h020304, 2'd0, 8'h00, 24'h020304);
        push(24'h030405, 2'd0, 8'h00, 24'h030405);
        push(24'h040506, 2'd0, 8'h00, 24'h040506);
        push(24'h050607, 2'd0, 8'h00, 24'h050607);
        push(24'h060708, 2'd0, 8'h00, 24'h060708);
        push(24'h070809, 2'd0, 8'h00, 24'h070809);
        push(24'h080808, 2'd0, 8'h00, 24'h080808);
        wait_idle("mode0");
        lat_arm = 1'b0;
        check("latency", 32'(wr_cyc - rd_cyc), 32'd2);

        // Operation vectors, then a 0->1 mode switch between adjacent reads
        @(posedge clock); #2;
        push(24'h00FF80, 2'd1, 8'h00, 24'hFF007F);
        push(24'h4080C0, 2'd2, 8'h00, 24'h808080);
        push(24'h7F8081, 2'd3, 8'h80, 24'h00FFFF);
        push(24'h123456, 2'd0, 8'h00, 24'h123456);
        push(24'h123456, 2'd1, 8'h00, 24'hEDCBA9);
        wait_idle("modes");

        // Back-pressure: 16 pixels with ff_full high for 20 cycles
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        ff_full = 1'b1;
        for (int i = 0; i < 16; i++) push({8'(i), 8'hA5, 8'(15 - i)}, 2'd0, 8'h00, {8'(i), 8'hA5, 8'(15 - i)});
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("credit_limit", 32'(n_rd - n_wr), OBUF_DEPTH);
        @(posedge clock); #2 ff_full = 1'b0;
        wait_idle("backpressure");
        check("delivered", 32'(n_wr), 32'd16);
`ifdef VIP_PIXEL_CORE_PIXCNT_EN
        check("pix_count16", pix_count, 32'd16);
`else
        check("pix_count16", pix_count, 32'd0);
`endif

        // Reset with three buffered pixels and a fourth read's data arriving during reset
        @(posedge clock); #2;
        ff_full = 1'b1;
        push(24'hAAAAAA, 2'd0, 8'h00, 24'hAAAAAA);
        push(24'hBBBBBB, 2'd0, 8'h00, 24'hBBBBBB);
        push(24'hCCCCCC, 2'd0, 8'h00, 24'hCCCCCC);
        push(24'hDDDDDD, 2'd0, 8'h00, 24'hDDDDDD);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (ff_rdreq && up_q.size() == 1) found = 1'b1;
        end
        check("fourth_read_seen", {31'd0, found}, 32'd1);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        ff_full = 1'b0;
        @(negedge clock);
        check("post_rst_wrreq", {31'd0, ff_wrreq}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_pix_count", pix_count, 32'd0);
        check("post_rst_wdata", {8'd0, ff_wdata}, 32'd0);
        repeat (10) @(negedge clock);
        check("post_rst_writes", 32'(n_wr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
